// File: rtl/gj_axis_uart_autobaud_pkg.sv
// Shared types and constants for the UART autobaud calibrator and its RX helpers.
package gj_axis_uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_WAIT_IDLE  = 3'd1,
      ST_WAIT_START = 3'd2,
      ST_MEASURE    = 3'd3,
      ST_CALC       = 3'd4
   } ab_state_e;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_TIMEOUT = 2'd1;
   localparam logic [1:0] ERR_FORMAT  = 2'd2;
   localparam logic [1:0] ERR_RANGE   = 2'd3;

   localparam logic [7:0] SYNC_CHAR = 8'h55;

endpackage

// File: rtl/gj_axis_uart_autobaud_if.sv
// Control/status bundle between the UART top (master) and the autobaud calibrator (slave).
interface gj_axis_uart_autobaud_if;
   logic        rxd;
   logic        cal_start;
   logic        cal_abort;
   logic        div_wr;
   logic [15:0] div_wdata;
   logic [15:0] clkDivX16;
   logic        baud_rst;
   logic        busy;
   logic        locked;
   logic        done;
   logic        err;
   logic [1:0]  err_code;

   modport slave (
      input  rxd, cal_start, cal_abort, div_wr, div_wdata,
      output clkDivX16, baud_rst, busy, locked, done, err, err_code
   );

   modport master (
      output rxd, cal_start, cal_abort, div_wr, div_wdata,
      input  clkDivX16, baud_rst, busy, locked, done, err, err_code
   );
endinterface

// File: rtl/gj_axis_uart_autobaud_rx_sync.sv
// Two-flop synchroniser for an asynchronous serial line with rise/fall strobes.
module gj_axis_uart_rx_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic rxd_i,
   output logic rxd_s_o,
   output logic rise_o,
   output logic fall_o
);

   logic s1_q, s2_q, prev_q;

   // Reset to the idle (mark) level so reset release never looks like a start edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q   <= 1'b1;
         s2_q   <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         s1_q   <= rxd_i;
         s2_q   <= s1_q;
         prev_q <= s2_q;
      end
   end

   assign rxd_s_o = s2_q;
   assign rise_o  = s2_q & ~prev_q;
   assign fall_o  = ~s2_q & prev_q;

endmodule

// File: rtl/gj_axis_uart_autobaud.sv
// Autobaud calibrator: times a received 0x55 and programs the x16 baud divider.
//   state         | meaning
//   ST_IDLE       | waiting for cal_start or a direct divider write
//   ST_WAIT_IDLE  | need IDLE_CYC consecutive mark cycles on rxd
//   ST_WAIT_START | waiting for the start-bit falling edge
//   ST_MEASURE    | timing 8 edges, checking each segment against the first
//   ST_CALC       | one cycle: divider = round(total / 128), range check
module gj_axis_uart_autobaud
   import gj_axis_uart_pkg::*;
#(
   parameter int          CNT_W       = 24,
   parameter int          IDLE_CYC    = 1024,
   parameter int          TIMEOUT_CYC = 10_000_000,
   parameter int          MIN_DIV     = 2,
   parameter logic [15:0] DIV_RST     = 16'd54
) (
   input logic                     clk,
   input logic                     rst_n,
   gj_axis_uart_autobaud_if.slave  bus
);

   ab_state_e        state_q;
   logic [CNT_W-1:0] idle_q, tot_q, seg_q, seg0_q, to_q;
   logic [2:0]       edges_q;
   logic [15:0]      div_q;
   logic             busy_q, baud_rst_q, locked_q, done_q, err_q;
   logic [1:0]       err_code_q;

   logic             rxd_s, rxd_rise, rxd_fall, any_edge;
   logic [CNT_W-1:0] seg_cur, seg_dev;
   logic [CNT_W:0]   div_full;
   logic             fail;
   logic [1:0]       fail_code;

   gj_axis_uart_rx_sync u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .rxd_i   (bus.rxd),
      .rxd_s_o (rxd_s),
      .rise_o  (rxd_rise),
      .fall_o  (rxd_fall)
   );

   assign any_edge = rxd_rise | rxd_fall;
   assign seg_cur  = seg_q + CNT_W'(1);
   assign seg_dev  = (seg_cur >= seg0_q) ? (seg_cur - seg0_q) : (seg0_q - seg_cur);
   // total covers 8 bit times = 128 divider ticks; +64 rounds to nearest
   assign div_full = ({1'b0, tot_q} + (CNT_W+1)'(64)) >> 7;

   always_comb begin
      fail      = 1'b0;
      fail_code = ERR_NONE;
      if (state_q != ST_IDLE) begin
         if (to_q == '0 || tot_q == '1 || seg_q == '1) begin
            fail      = 1'b1;
            fail_code = ERR_TIMEOUT;
         end else if (state_q == ST_MEASURE && any_edge && edges_q != 3'd0 &&
                      seg_dev > (seg0_q >> 2)) begin
            fail      = 1'b1;
            fail_code = ERR_FORMAT;
         end else if (state_q == ST_CALC &&
                      (div_full < (CNT_W+1)'(MIN_DIV) || div_full > (CNT_W+1)'(16'hFFFF))) begin
            fail      = 1'b1;
            fail_code = ERR_RANGE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         idle_q     <= '0;
         tot_q      <= '0;
         seg_q      <= '0;
         seg0_q     <= '0;
         to_q       <= '0;
         edges_q    <= '0;
         div_q      <= DIV_RST;
         busy_q     <= 1'b0;
         baud_rst_q <= 1'b0;
         locked_q   <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         if (state_q != ST_IDLE) to_q <= to_q - CNT_W'(1);

         if (state_q == ST_IDLE) begin
            baud_rst_q <= 1'b0;
            if (bus.div_wr) begin
               div_q      <= bus.div_wdata;
               locked_q   <= 1'b0;
               baud_rst_q <= 1'b1;
            end
            if (bus.cal_start) begin
               state_q    <= ST_WAIT_IDLE;
               busy_q     <= 1'b1;
               baud_rst_q <= 1'b1;
               err_code_q <= ERR_NONE;
               idle_q     <= '0;
               to_q       <= CNT_W'(TIMEOUT_CYC - 1);
            end
         end else if (bus.cal_abort) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            baud_rst_q <= 1'b0;
         end else if (fail) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            baud_rst_q <= 1'b0;
            err_q      <= 1'b1;
            err_code_q <= fail_code;
         end else begin
            unique case (state_q)
               ST_WAIT_IDLE: begin
                  if (!rxd_s)                               idle_q  <= '0;
                  else if (idle_q == CNT_W'(IDLE_CYC - 1))  state_q <= ST_WAIT_START;
                  else                                      idle_q  <= idle_q + CNT_W'(1);
               end
               ST_WAIT_START: begin
                  if (rxd_fall) begin
                     state_q <= ST_MEASURE;
                     tot_q   <= '0;
                     seg_q   <= '0;
                     edges_q <= '0;
                  end
               end
               ST_MEASURE: begin
                  tot_q <= tot_q + CNT_W'(1);
                  if (any_edge) begin
                     seg_q   <= '0;
                     edges_q <= edges_q + 3'd1;
                     if (edges_q == 3'd0) seg0_q  <= seg_cur;
                     if (edges_q == 3'd7) state_q <= ST_CALC;
                  end else begin
                     seg_q <= seg_cur;
                  end
               end
               ST_CALC: begin
                  state_q    <= ST_IDLE;
                  div_q      <= div_full[15:0];
                  locked_q   <= 1'b1;
                  done_q     <= 1'b1;
                  busy_q     <= 1'b0;
                  baud_rst_q <= 1'b0;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign bus.clkDivX16 = div_q;
   assign bus.baud_rst  = baud_rst_q;
   assign bus.busy      = busy_q;
   assign bus.locked    = locked_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_gj_axis_uart_autobaud.sv
// Directed bench for the autobaud calibrator: sync-character timing, error paths, abort, direct write.
module tb_gj_axis_uart_autobaud;
   import gj_axis_uart_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   gj_axis_uart_autobaud_if bus ();
   gj_axis_uart_autobaud_if bus2 ();

   gj_axis_uart_autobaud u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   gj_axis_uart_autobaud #(.TIMEOUT_CYC(5000)) u_to (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   int checks = 0;
   int errors = 0;

   int   done_cnt = 0, err_cnt = 0, both_cnt = 0;
   logic done_busy, done_baud, done_prev_baud, err_busy;
   logic prev_baud = 1'b0;

   always @(negedge clk) begin
      if (bus.done && bus.err) both_cnt++;
      if (bus.done) begin
         done_cnt++;
         done_busy      = bus.busy;
         done_baud      = bus.baud_rst;
         done_prev_baud = prev_baud;
      end
      if (bus.err) begin
         err_cnt++;
         err_busy = bus.busy;
      end
      prev_baud = bus.baud_rst;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      bus.rxd = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input int t);
      bus.rxd = 1'b0;
      repeat (t) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         bus.rxd = b[i];
         repeat (t) @(negedge clk);
      end
      bus.rxd = 1'b1;
      repeat (t) @(negedge clk);
   endtask

   task automatic start_cal();
      bus.cal_start = 1'b1;
      @(negedge clk);
      bus.cal_start = 1'b0;
   endtask

   task automatic abort_cal();
      bus.cal_abort = 1'b1;
      @(negedge clk);
      bus.cal_abort = 1'b0;
   endtask

   int d0, e0;

   initial begin
      bus.rxd = 1'b1;  bus.cal_start = 1'b0;  bus.cal_abort = 1'b0;
      bus.div_wr = 1'b0;  bus.div_wdata = 16'd0;
      bus2.rxd = 1'b1; bus2.cal_start = 1'b0; bus2.cal_abort = 1'b0;
      bus2.div_wr = 1'b0; bus2.div_wdata = 16'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset state
      check("rst_div",      32'(bus.clkDivX16), 32'd54);
      check("rst_baud_rst", 32'(bus.baud_rst),  32'd0);
      check("rst_busy",     32'(bus.busy),      32'd0);
      check("rst_locked",   32'(bus.locked),    32'd0);
      check("rst_err_code", 32'(bus.err_code),  32'd0);
      check("rst_done_err", 32'({bus.done, bus.err}), 32'd0);

      // 0x55 at 868 cycles/bit: total 6944, div (6944+64)>>7 = 54
      d0 = done_cnt; e0 = err_cnt;
      start_cal();
      check("t2_busy_up",     32'(bus.busy),     32'd1);
      check("t2_baud_rst_up", 32'(bus.baud_rst), 32'd1);
      idle(2000);
      send_byte(SYNC_CHAR, 868);
      idle(10);
      check("t2_done_cnt",   32'(done_cnt - d0), 32'd1);
      check("t2_err_cnt",    32'(err_cnt - e0),  32'd0);
      check("t2_div",        32'(bus.clkDivX16), 32'd54);
      check("t2_locked",     32'(bus.locked),    32'd1);
      check("t2_baud_prev",  32'(done_prev_baud), 32'd1);
      check("t2_baud_at_done", 32'(done_baud),   32'd0);
      check("t2_busy_at_done", 32'(done_busy),   32'd0);

      // 0x55 at 1024 cycles/bit: total 8192, div 64
      d0 = done_cnt; e0 = err_cnt;
      start_cal();
      idle(2000);
      send_byte(SYNC_CHAR, 1024);
      idle(10);
      check("t3a_done_cnt", 32'(done_cnt - d0), 32'd1);
      check("t3a_div",      32'(bus.clkDivX16), 32'd64);

      // 0x55 at 16 cycles/bit: total 128, div 1 -> range error
      d0 = done_cnt; e0 = err_cnt;
      start_cal();
      idle(2000);
      send_byte(SYNC_CHAR, 16);
      idle(10);
      check("t3b_err_cnt",  32'(err_cnt - e0),  32'd1);
      check("t3b_done_cnt", 32'(done_cnt - d0), 32'd0);
      check("t3b_err_code", 32'(bus.err_code),  32'(ERR_RANGE));
      check("t3b_div",      32'(bus.clkDivX16), 32'd64);
      check("t3b_locked",   32'(bus.locked),    32'd1);

      // 0x41: third segment is 5 bit times -> format error
      d0 = done_cnt; e0 = err_cnt;
      start_cal();
      check("t4_err_code_clr", 32'(bus.err_code), 32'd0);
      idle(2000);
      send_byte(8'h41, 1024);
      idle(10);
      check("t4_err_cnt",  32'(err_cnt - e0),  32'd1);
      check("t4_done_cnt", 32'(done_cnt - d0), 32'd0);
      check("t4_err_code", 32'(bus.err_code),  32'(ERR_FORMAT));
      check("t4_busy_at_err", 32'(err_busy),   32'd0);
      check("t4_locked",   32'(bus.locked),    32'd1);
      check("t4_div",      32'(bus.clkDivX16), 32'd64);

      // Timeout on the 5000-cycle instance with rxd stuck at mark
      bus2.cal_start = 1'b1;
      @(negedge clk);
      bus2.cal_start = 1'b0;
      repeat (4999) @(negedge clk);
      check("t5_to_before_err",  32'(bus2.err),  32'd0);
      check("t5_to_before_busy", 32'(bus2.busy), 32'd1);
      @(negedge clk);
      check("t5_to_err",      32'(bus2.err),       32'd1);
      check("t5_to_err_code", 32'(bus2.err_code),  32'(ERR_TIMEOUT));
      check("t5_to_busy",     32'(bus2.busy),      32'd0);
      check("t5_to_div",      32'(bus2.clkDivX16), 32'd54);

      // Abort part-way through a measurement
      d0 = done_cnt; e0 = err_cnt;
      start_cal();
      idle(1100);
      bus.rxd = 1'b0;
      repeat (868) @(negedge clk);
      bus.rxd = 1'b1;
      repeat (100) @(negedge clk);
      check("t5_abort_busy_pre", 32'(bus.busy), 32'd1);
      abort_cal();
      check("t5_abort_busy",     32'(bus.busy),     32'd0);
      check("t5_abort_baud_rst", 32'(bus.baud_rst), 32'd0);
      idle(3000);
      check("t5_abort_no_done", 32'(done_cnt - d0), 32'd0);
      check("t5_abort_no_err",  32'(err_cnt - e0),  32'd0);
      check("t5_abort_div",     32'(bus.clkDivX16), 32'd64);

      // Direct divider write in IDLE
      bus.div_wdata = 16'd100;
      bus.div_wr = 1'b1;
      @(negedge clk);
      bus.div_wr = 1'b0;
      check("t6_div",      32'(bus.clkDivX16), 32'd100);
      check("t6_locked",   32'(bus.locked),    32'd0);
      check("t6_baud_on",  32'(bus.baud_rst),  32'd1);
      @(negedge clk);
      check("t6_baud_off", 32'(bus.baud_rst),  32'd0);

      // Write while busy is ignored
      start_cal();
      bus.div_wdata = 16'd200;
      bus.div_wr = 1'b1;
      @(negedge clk);
      bus.div_wr = 1'b0;
      check("t6_busy_wr_div", 32'(bus.clkDivX16), 32'd100);
      abort_cal();

      // Same-cycle write and start: write lands, calibration begins
      bus.div_wdata = 16'd77;
      bus.div_wr = 1'b1;
      bus.cal_start = 1'b1;
      @(negedge clk);
      bus.div_wr = 1'b0;
      bus.cal_start = 1'b0;
      check("t6_both_div",  32'(bus.clkDivX16), 32'd77);
      check("t6_both_busy", 32'(bus.busy),      32'd1);
      abort_cal();

      check("done_err_exclusive", 32'(both_cnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
